// File: rtl/walk_req_bank.sv
// walk_req_bank: debounced pedestrian walk request latches with a
// round-robin single-offer grant handshake.
module walk_req_bank #(
  parameter int NUM_CH = 4,
  parameter int DEBOUNCE_CYC = 4,
  localparam int CW = $clog2(NUM_CH),
  localparam int NW = $clog2(NUM_CH + 1)
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [NUM_CH-1:0] Button_In,
  input  logic [NUM_CH-1:0] Ch_Enable,
  input  logic [NUM_CH-1:0] Clear,
  input  logic              Grant_Ack,
  output logic              Grant_Valid,
  output logic [CW-1:0]     Grant_Ch,
  output logic [NUM_CH-1:0] Pending_Vec,
  output logic [NW-1:0]     Pending_Cnt
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state;
  logic [NUM_CH-1:0] s1, s2, set_v, clr_v, pv_n;
  logic [7:0] cnt [NUM_CH];
  logic [CW-1:0] ptr, sel;
  logic [NW-1:0] cnt_n;
  logic found, ack;
  assign ack = (state == OFFER) && Grant_Ack;
  // A set wins over a same-cycle clear; a disabled channel never holds a request.
  always_comb begin
    cnt_n = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      set_v[i] = s2[i] && (cnt[i] == 8'(DEBOUNCE_CYC - 1));
      clr_v[i] = Clear[i] | (ack && (Grant_Ch == CW'(i)));
      pv_n[i] = Ch_Enable[i] & (set_v[i] | (Pending_Vec[i] & ~clr_v[i]));
      cnt_n = cnt_n + NW'(pv_n[i]);
    end
  end
  // First pending channel at or after ptr, wrapping.
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      logic [CW-1:0] idx;
      idx = CW'((int'(ptr) + k) % NUM_CH);
      if (!found && Pending_Vec[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1 <= '0;
      s2 <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
      Pending_Vec <= '0;
      Pending_Cnt <= '0;
    end else begin
      s1 <= Button_In;
      s2 <= s1;
      for (int i = 0; i < NUM_CH; i++)
        cnt[i] <= !s2[i] ? 8'd0 : (cnt[i] == 8'(DEBOUNCE_CYC)) ? cnt[i] : cnt[i] + 8'd1;
      Pending_Vec <= pv_n;
      Pending_Cnt <= cnt_n;
    end
  end
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= IDLE;
      Grant_Valid <= 1'b0;
      Grant_Ch <= '0;
      ptr <= '0;
    end else if (state == IDLE) begin
      if (found) begin
        Grant_Ch <= sel;
        Grant_Valid <= 1'b1;
        state <= OFFER;
      end
    end else if (Grant_Ack) begin
      ptr <= (Grant_Ch == CW'(NUM_CH - 1)) ? '0 : Grant_Ch + 1'b1;
      Grant_Valid <= 1'b0;
      state <= IDLE;
    end else if (!pv_n[Grant_Ch]) begin
      Grant_Valid <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_walk_req_bank.sv
// tb_walk_req_bank: directed scenarios with a queue of expected grant channels.
module tb_walk_req_bank;
  logic clk_r = 1'b0;
  logic Rst_n = 1'b0;
  logic [3:0] Button_In = '0, Ch_Enable = 4'hF, Clear = '0;
  logic Grant_Ack = 1'b0;
  logic Grant_Valid;
  logic [1:0] Grant_Ch;
  logic [3:0] Pending_Vec;
  logic [2:0] Pending_Cnt;
  int passed = 0, total = 0;
  int q[$];
  always #5 clk_r = ~clk_r;
  walk_req_bank #(.NUM_CH(4), .DEBOUNCE_CYC(4)) dut (
    .Clk(clk_r), .Rst_n(Rst_n), .Button_In(Button_In), .Ch_Enable(Ch_Enable),
    .Clear(Clear), .Grant_Ack(Grant_Ack), .Grant_Valid(Grant_Valid),
    .Grant_Ch(Grant_Ch), .Pending_Vec(Pending_Vec), .Pending_Cnt(Pending_Cnt)
  );
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk_r);
    #1;
  endtask
  task automatic do_reset();
    Rst_n = 1'b0;
    Button_In = '0;
    Clear = '0;
    Grant_Ack = 1'b0;
    Ch_Enable = 4'hF;
    tick(2);
    Rst_n = 1'b1;
    tick(1);
  endtask
  // Wait for an offer, compare against the scoreboard head, ack it.
  task automatic serve();
    int k = 0;
    int e;
    while (!Grant_Valid && k < 40) begin
      tick(1);
      k++;
    end
    if (!Grant_Valid) check("grant_timeout", 0, 1);
    else begin
      e = (q.size() > 0) ? q.pop_front() : -1;
      check("grant_ch", Grant_Ch, e);
      Grant_Ack = 1'b1;
      tick(1);
      Grant_Ack = 1'b0;
      check("grant_gap", Grant_Valid, 0);
    end
  endtask
  initial begin
    tick(1);
    check("rst_pv", Pending_Vec, 0);
    check("rst_cnt", Pending_Cnt, 0);
    check("rst_gv", Grant_Valid, 0);
    check("rst_gch", Grant_Ch, 0);
    do_reset();
    // single press: pending exactly at edge 6, offer at edge 7
    Button_In = 4'b0100;
    q.push_back(2);
    tick(5);
    check("press_not_early", Pending_Vec, 0);
    tick(1);
    check("press_pv", Pending_Vec, 4'b0100);
    check("press_cnt", Pending_Cnt, 1);
    check("press_gv_idle", Grant_Valid, 0);
    tick(1);
    check("press_gv", Grant_Valid, 1);
    check("press_gch", Grant_Ch, 2);
    tick(1);
    check("press_hold_gch", Grant_Ch, 2);
    serve();
    check("ack_clears", Pending_Vec, 0);
    tick(2);
    check("one_per_press", Pending_Vec, 0);
    Button_In = '0;
    tick(6);
    // glitch
    do_reset();
    Button_In = 4'b0010;
    tick(3);
    Button_In = '0;
    tick(8);
    check("glitch_pv", Pending_Vec, 0);
    check("glitch_gv", Grant_Valid, 0);
    // round robin
    do_reset();
    Button_In = 4'b1011;
    tick(8);
    Button_In = '0;
    check("rr_cnt", Pending_Cnt, 3);
    q.push_back(0); q.push_back(1); q.push_back(3);
    repeat (3) serve();
    check("rr_drained", Pending_Vec, 0);
    Button_In = 4'b1000;
    tick(2);
    Button_In = 4'b1001;
    tick(8);
    Button_In = '0;
    check("rr2_cnt", Pending_Cnt, 2);
    q.push_back(3); q.push_back(0);
    repeat (2) serve();
    // collision: clear on the setting edge loses
    do_reset();
    Button_In = 4'b0100;
    tick(5);
    Clear = 4'b0100;
    tick(1);
    Clear = '0;
    Button_In = '0;
    check("collide_pv", Pending_Vec, 4'b0100);
    Clear = 4'b0100;
    tick(1);
    Clear = '0;
    check("clear_pv", Pending_Vec, 0);
    tick(1);
    check("clear_withdraw", Grant_Valid, 0);
    tick(4);
    // withdraw keeps pointer at 0, so 0 precedes 3 afterwards
    do_reset();
    Button_In = 4'b0010;
    tick(8);
    check("wd_gv", Grant_Valid, 1);
    check("wd_gch", Grant_Ch, 1);
    Button_In = '0;
    Clear = 4'b0010;
    tick(1);
    Clear = '0;
    check("wd_gv_drop", Grant_Valid, 0);
    check("wd_pv", Pending_Vec, 0);
    Button_In = 4'b1001;
    tick(8);
    Button_In = '0;
    q.push_back(0); q.push_back(3);
    repeat (2) serve();
    // channel enable
    do_reset();
    Ch_Enable = 4'b1110;
    Button_In = 4'b0001;
    tick(8);
    check("dis_pv", Pending_Vec, 0);
    check("dis_gv", Grant_Valid, 0);
    Ch_Enable = 4'hF;
    tick(2);
    check("dis_no_late_set", Pending_Vec, 0);
    Button_In = 4'b1000;
    tick(7);
    check("en_pv", Pending_Vec, 4'b1000);
    Ch_Enable = 4'b0111;
    tick(1);
    check("en_drop_pv", Pending_Vec, 0);
    Button_In = '0;
    Ch_Enable = 4'hF;
    tick(4);
    // async reset mid-offer, held buttons re-qualify from zero
    do_reset();
    Button_In = 4'b0111;
    tick(8);
    check("rstop_cnt", Pending_Cnt, 3);
    check("rstop_gv", Grant_Valid, 1);
    #3 Rst_n = 1'b0;
    #1;
    check("async_pv", Pending_Vec, 0);
    check("async_cnt", Pending_Cnt, 0);
    check("async_gv", Grant_Valid, 0);
    check("async_gch", Grant_Ch, 0);
    #1 Rst_n = 1'b1;
    tick(5);
    check("requal_early", Pending_Vec, 0);
    tick(1);
    check("requal_pv", Pending_Vec, 4'b0111);
    Button_In = '0;
    q.push_back(0); q.push_back(1); q.push_back(2);
    repeat (3) serve();
    check("sb_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
